// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of insMem.
// Owns the PC, issues the instruction address, and captures returned words
// into a small prefetch FIFO. The controller consumes them over valid/ack.
// Supports PC redirect with flush, fetch halt, and wrap at the memory end.
module fetch_unit #(
  parameter int ADDR_W    = 10,
  parameter int INS_W     = 16,
  parameter int DEPTH     = 2,
  parameter int MEM_DEPTH = 1000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] address,
  input  logic [INS_W-1:0]  instruction,
  output logic [INS_W-1:0]  ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ack,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              addr_fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Last legal address and the exclusive upper bound. The bound is one bit
  // wider so that a MEM_DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              addr_fault_q, addr_fault_d;
  logic [INS_W-1:0]  ins_buf_q [DEPTH];
  logic [INS_W-1:0]  ins_buf_d [DEPTH];
  logic [ADDR_W-1:0] pc_buf_q  [DEPTH];
  logic [ADDR_W-1:0] pc_buf_d  [DEPTH];

  // Handshake qualifiers
  logic valid_s;
  logic pop_s;
  logic push_s;
  logic target_ok_s;

  assign valid_s     = (count_q != {CNT_W{1'b0}});
  assign pop_s       = ir_ack & valid_s;
  // A push can also happen on a full buffer when the head leaves this cycle,
  // which keeps throughput at one instruction per cycle.
  assign push_s      = ~redirect_en & ~halt & ((count_q < CNT_FULL) | pop_s);
  assign target_ok_s = ({1'b0, redirect_addr} < ADDR_LIM);

  // Next-state computation: redirect flushes and reloads PC, otherwise push/pop.
  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    addr_fault_d = addr_fault_q;
    ins_buf_d    = ins_buf_q;
    pc_buf_d     = pc_buf_q;

    if (redirect_en) begin
      // Flush: any ack this cycle is dropped along with the buffered entries.
      count_d  = {CNT_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      if (target_ok_s) begin
        pc_d = redirect_addr;
      end else begin
        // Out-of-range target: park at 0 so address stays legal, and flag it.
        pc_d         = {ADDR_W{1'b0}};
        addr_fault_d = 1'b1;
      end
    end else begin
      if (push_s) begin
        ins_buf_d[wr_ptr_q] = instruction;
        pc_buf_d[wr_ptr_q]  = pc_q;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        if (pc_q == LAST_ADDR) begin
          pc_d = {ADDR_W{1'b0}};
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end else begin
        pc_d = pc_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= {ADDR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      addr_fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_buf_q[i] <= {INS_W{1'b0}};
        pc_buf_q[i]  <= {ADDR_W{1'b0}};
      end
    end else begin
      pc_q         <= pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      addr_fault_q <= addr_fault_d;
      ins_buf_q    <= ins_buf_d;
      pc_buf_q     <= pc_buf_d;
    end
  end

  // Outputs come straight from state: no bypass from the memory input.
  assign address    = pc_q;
  assign ir         = ins_buf_q[rd_ptr_q];
  assign ir_pc      = pc_buf_q[rd_ptr_q];
  assign ir_valid   = valid_s;
  assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with a scoreboard of expected
// consumed instructions plus direct checks of address/valid/fault.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  address;
  logic [15:0] instruction;
  logic [15:0] ir;
  logic [9:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ack;
  logic        redirect_en;
  logic [9:0]  redirect_addr;
  logic        halt;
  logic        addr_fault;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:1023];
  logic [25:0] exp_q [$];

  fetch_unit #(.ADDR_W(10), .INS_W(16), .DEPTH(2), .MEM_DEPTH(1000)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .instruction  (instruction),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ir_ack       (ir_ack),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .halt         (halt),
    .addr_fault   (addr_fault)
  );

  // Combinational instruction memory model
  assign instruction = mem[address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input int pc);
    logic [9:0] p;
    p = 10'(pc);
    exp_q.push_back({p, mem[p]});
  endtask

  task automatic do_reset();
    rst = 1'b1; ir_ack = 1'b0; redirect_en = 1'b0; halt = 1'b0; redirect_addr = 10'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every consumed head must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && !redirect_en) begin
      chk("addr_range", 32'(address < 10'd1000), 32'd1);
      if (ir_valid && ir_ack) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pc", 32'(ir_pc), 32'hFFFF_FFFF);
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          chk("sb_ir_pc", 32'(ir_pc), 32'(e[25:16]));
          chk("sb_ir", 32'(ir), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h5000 + 16'(i);
    for (int i = 2; i < 21; i++) mem[i] = 16'h3000 + 16'(i);
    mem[0]  = 16'h8080;
    mem[1]  = 16'h01F4;
    mem[21] = 16'h1401;

    // Reset state
    rst = 1'b1; ir_ack = 1'b0; redirect_en = 1'b0; halt = 1'b0; redirect_addr = 10'd0;
    step();
    step();
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_fault", 32'(addr_fault), 32'd0);
    rst = 1'b0;

    // Basic streaming with constant ack
    exp_push(0); exp_push(1);
    ir_ack = 1'b1;
    step();
    chk("s1_valid", 32'(ir_valid), 32'd1);
    chk("s1_ir0", 32'(ir), 32'h8080);
    chk("s1_pc0", 32'(ir_pc), 32'd0);
    step();
    chk("s1_ir1", 32'(ir), 32'h01F4);
    chk("s1_pc1", 32'(ir_pc), 32'd1);
    step();
    ir_ack = 1'b0;
    chk("s1_pc2", 32'(ir_pc), 32'd2);
    chk("s1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: fills to 2, then drains in order
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("bp_address", 32'(address), (i < 2) ? 32'(i) : 32'd2);
      chk("bp_ir", 32'(ir), 32'h8080);
      chk("bp_ir_pc", 32'(ir_pc), 32'd0);
    end
    exp_push(0); exp_push(1); exp_push(2); exp_push(3);
    ir_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("bp_drain_pc", 32'(ir_pc), 32'(i));
    end
    ir_ack = 1'b0;
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Redirect with a full buffer
    do_reset();
    step(); step(); step();
    redirect_en = 1'b1; redirect_addr = 10'd21;
    step();
    chk("rd_valid0", 32'(ir_valid), 32'd0);
    chk("rd_address", 32'(address), 32'd21);
    redirect_en = 1'b0;
    exp_push(21); exp_push(22);
    step();
    chk("rd_valid1", 32'(ir_valid), 32'd1);
    chk("rd_ir", 32'(ir), 32'h1401);
    chk("rd_ir_pc", 32'(ir_pc), 32'd21);
    ir_ack = 1'b1;
    step();
    step();
    ir_ack = 1'b0;
    chk("rd_sb_empty", 32'(exp_q.size()), 32'd0);

    // Wrap at the end of memory
    do_reset();
    ir_ack = 1'b1; redirect_en = 1'b1; redirect_addr = 10'd999;
    exp_push(999); exp_push(0); exp_push(1);
    step();
    chk("wr_address999", 32'(address), 32'd999);
    chk("wr_valid0", 32'(ir_valid), 32'd0);
    redirect_en = 1'b0;
    step();
    chk("wr_head999", 32'(ir_pc), 32'd999);
    chk("wr_address0", 32'(address), 32'd0);
    step();
    chk("wr_head0", 32'(ir_pc), 32'd0);
    step();
    chk("wr_head1", 32'(ir_pc), 32'd1);
    step();
    ir_ack = 1'b0;
    chk("wr_sb_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-range redirect and sticky fault
    do_reset();
    redirect_en = 1'b1; redirect_addr = 10'd1000;
    step();
    chk("oor_fault", 32'(addr_fault), 32'd1);
    chk("oor_address", 32'(address), 32'd0);
    chk("oor_valid", 32'(ir_valid), 32'd0);
    redirect_en = 1'b0;
    step();
    chk("oor_ir_pc", 32'(ir_pc), 32'd0);
    redirect_en = 1'b1; redirect_addr = 10'd5;
    step();
    chk("oor_sticky", 32'(addr_fault), 32'd1);
    chk("oor_address5", 32'(address), 32'd5);
    redirect_en = 1'b0;
    step();
    chk("oor_sticky2", 32'(addr_fault), 32'd1);
    // Reset on the same edge as a redirect: reset wins
    redirect_en = 1'b1; redirect_addr = 10'd50; rst = 1'b1;
    step();
    chk("rr_address", 32'(address), 32'd0);
    chk("rr_fault", 32'(addr_fault), 32'd0);
    chk("rr_valid", 32'(ir_valid), 32'd0);
    rst = 1'b0; redirect_en = 1'b0;
    step();
    chk("rr_ir_pc", 32'(ir_pc), 32'd0);
    chk("rr_address1", 32'(address), 32'd1);

    // Halt: buffer drains, PC holds, then resumes
    do_reset();
    step(); step();
    halt = 1'b1; ir_ack = 1'b1;
    exp_push(0); exp_push(1);
    step();
    chk("h_address_a", 32'(address), 32'd2);
    chk("h_valid_a", 32'(ir_valid), 32'd1);
    chk("h_pc_a", 32'(ir_pc), 32'd1);
    step();
    chk("h_address_b", 32'(address), 32'd2);
    chk("h_valid_b", 32'(ir_valid), 32'd0);
    step();
    chk("h_address_c", 32'(address), 32'd2);
    chk("h_valid_c", 32'(ir_valid), 32'd0);
    halt = 1'b0; ir_ack = 1'b0;
    step();
    chk("h_resume_valid", 32'(ir_valid), 32'd1);
    chk("h_resume_pc", 32'(ir_pc), 32'd2);
    chk("h_resume_addr", 32'(address), 32'd3);
    chk("h_sb_empty", 32'(exp_q.size()), 32'd0);

    // Redirect and ack together: ack dropped, buffer empty
    do_reset();
    step(); step();
    redirect_en = 1'b1; redirect_addr = 10'd7; ir_ack = 1'b1;
    step();
    chk("ra_valid", 32'(ir_valid), 32'd0);
    chk("ra_address", 32'(address), 32'd7);
    redirect_en = 1'b0; ir_ack = 1'b0;
    step();
    chk("ra_ir_pc", 32'(ir_pc), 32'd7);
    chk("ra_ir", 32'(ir), 32'h3007);
    chk("ra_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
